// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter feeding the single register_file write port.
// The pipeline writeback always wins. Multi-cycle results wait in a small
// FIFO and drain in idle slots. busy_mask marks registers that still have
// an uncommitted multi-cycle write.
module regfile_wb_arbiter #(
  parameter int DEPTH      = 4,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      pipe_wr_en,
  input  logic [ADDR_WIDTH-1:0]     pipe_wr_reg,
  input  logic [DATA_WIDTH-1:0]     pipe_wr_data,
  input  logic                      mc_valid,
  output logic                      mc_ready,
  input  logic [ADDR_WIDTH-1:0]     mc_wr_reg,
  input  logic [DATA_WIDTH-1:0]     mc_wr_data,
  output logic                      wr_en,
  output logic [ADDR_WIDTH-1:0]     wr_reg,
  output logic [DATA_WIDTH-1:0]     wr_data,
  output logic [$clog2(DEPTH):0]    fifo_count,
  output logic [2**ADDR_WIDTH-1:0]  busy_mask
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // Records which source produced the write currently on wr_*
  localparam logic [0:0] SRC_PIPE = 1'b0;
  localparam logic [0:0] SRC_MC   = 1'b1;

  logic [ADDR_WIDTH-1:0] q_reg  [DEPTH];
  logic [DATA_WIDTH-1:0] q_data [DEPTH];
  logic [PTR_W-1:0]      rd_ptr;
  logic [PTR_W-1:0]      wr_ptr;
  logic [CNT_W-1:0]      count;
  logic [0:0]            src;
  logic                  pipe_sel;
  logic                  push;
  logic                  pop;

  // Ready comes from the registered count only; a pop this cycle does not free a slot early
  assign mc_ready   = !rst && (count < CNT_W'(DEPTH));
  assign fifo_count = count;

  // Writes to x0 are treated as no-ops on both sources
  assign pipe_sel = pipe_wr_en && (pipe_wr_reg != '0);
  assign push     = mc_valid && mc_ready && (mc_wr_reg != '0);
  assign pop      = !pipe_sel && (count != '0);

  // FIFO storage; entries need no reset because count alone says which are valid
  always_ff @(posedge clk) begin
    if (push) begin
      q_reg[wr_ptr]  <= mc_wr_reg;
      q_data[wr_ptr] <= mc_wr_data;
    end
  end

  // Pointers, occupancy and the registered write-port outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count   <= '0;
      wr_en   <= 1'b0;
      wr_reg  <= '0;
      wr_data <= '0;
      src     <= SRC_PIPE;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase

      if (pipe_sel) begin
        wr_en   <= 1'b1;
        wr_reg  <= pipe_wr_reg;
        wr_data <= pipe_wr_data;
        src     <= SRC_PIPE;
      end else if (pop) begin
        wr_en   <= 1'b1;
        wr_reg  <= q_reg[rd_ptr];
        wr_data <= q_data[rd_ptr];
        src     <= SRC_MC;
      end else begin
        wr_en   <= 1'b0;
        wr_reg  <= '0;
        wr_data <= '0;
        src     <= SRC_PIPE;
      end
    end
  end

  // Pending multi-cycle destinations: queued entries plus the one being presented now
  always_comb begin
    logic [PTR_W-1:0] idx;
    busy_mask = '0;
    idx       = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = rd_ptr + PTR_W'(i);
      if (CNT_W'(i) < count) begin
        busy_mask[q_reg[idx]] = 1'b1;
      end
    end
    if (wr_en && (src == SRC_MC)) begin
      busy_mask[wr_reg] = 1'b1;
    end
    busy_mask[0] = 1'b0;
  end

  // Upstream must not issue a pipeline write to a register with a pending multi-cycle write
  a_no_waw: assert property (@(posedge clk) disable iff (rst)
    (pipe_wr_en && (pipe_wr_reg != '0)) |-> !busy_mask[pipe_wr_reg]);

  // A presented multi-cycle result must be held until it is accepted
  a_mc_hold: assert property (@(posedge clk) disable iff (rst)
    (mc_valid && !mc_ready) |=> mc_valid);

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Randomised and directed bench for regfile_wb_arbiter. A queue-based
// reference model predicts every cycle's outputs; a monitor compares them.
module tb_regfile_wb_arbiter;

  localparam int DEPTH = 4;
  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int CW    = $clog2(DEPTH) + 1;

  typedef struct {
    logic [AW-1:0] r;
    logic [DW-1:0] d;
  } wr_t;

  typedef struct {
    logic          en;
    logic [AW-1:0] r;
    logic [DW-1:0] d;
    logic [CW-1:0] cnt;
    logic          rdy;
    logic [31:0]   busy;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst;
  logic            pipe_wr_en;
  logic [AW-1:0]   pipe_wr_reg;
  logic [DW-1:0]   pipe_wr_data;
  logic            mc_valid;
  logic            mc_ready;
  logic [AW-1:0]   mc_wr_reg;
  logic [DW-1:0]   mc_wr_data;
  logic            wr_en;
  logic [AW-1:0]   wr_reg;
  logic [DW-1:0]   wr_data;
  logic [CW-1:0]   fifo_count;
  logic [31:0]     busy_mask;

  regfile_wb_arbiter #(.DEPTH(DEPTH), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst),
    .pipe_wr_en(pipe_wr_en), .pipe_wr_reg(pipe_wr_reg), .pipe_wr_data(pipe_wr_data),
    .mc_valid(mc_valid), .mc_ready(mc_ready), .mc_wr_reg(mc_wr_reg), .mc_wr_data(mc_wr_data),
    .wr_en(wr_en), .wr_reg(wr_reg), .wr_data(wr_data),
    .fifo_count(fifo_count), .busy_mask(busy_mask)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  exp_t expq[$];
  wr_t  mq[$];        // model of queued multi-cycle writes, in arrival order
  wr_t  mc_todo[$];   // multi-cycle results waiting to be offered to the DUT

  // Model of the write port as it stands after the most recent edge
  logic          m_en   = 1'b0;
  logic [AW-1:0] m_reg  = '0;
  logic [DW-1:0] m_data = '0;
  logic          m_mc   = 1'b0;
  bit            model_ok = 1'b0;

  logic [DW-1:0] rf_model [32];
  logic [DW-1:0] rf_dut   [32];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=0x%0h expected=0x%0h", name, cyc, act, expv);
    end
  endtask

  function automatic logic [31:0] model_busy();
    logic [31:0] b;
    b = '0;
    foreach (mq[i]) b[mq[i].r] = 1'b1;
    if (m_en && m_mc) b[m_reg] = 1'b1;
    b[0] = 1'b0;
    return b;
  endfunction

  // One clock: drive inputs, record the expected observable state, advance the model
  task automatic step(input bit r, input bit pe, input logic [AW-1:0] pr, input logic [DW-1:0] pd);
    exp_t e;
    wr_t  ent;
    bit   mv;
    bit   rdy_before;
    mv = (mc_todo.size() > 0);
    rst          = r;
    pipe_wr_en   = pe;
    pipe_wr_reg  = pr;
    pipe_wr_data = pd;
    mc_valid     = mv;
    mc_wr_reg    = mv ? mc_todo[0].r : '0;
    mc_wr_data   = mv ? mc_todo[0].d : '0;
    if (model_ok) begin
      e.en   = m_en;
      e.r    = m_reg;
      e.d    = m_data;
      e.cnt  = CW'(mq.size());
      e.rdy  = !r && (mq.size() < DEPTH);
      e.busy = model_busy();
      expq.push_back(e);
    end
    if (r) begin
      mq.delete();
      m_en = 1'b0; m_reg = '0; m_data = '0; m_mc = 1'b0;
      model_ok = 1'b1;
    end else begin
      rdy_before = (mq.size() < DEPTH);
      if (pe && pr != 0) begin
        m_en = 1'b1; m_reg = pr; m_data = pd; m_mc = 1'b0;
      end else if (mq.size() > 0) begin
        ent = mq.pop_front();
        m_en = 1'b1; m_reg = ent.r; m_data = ent.d; m_mc = 1'b1;
      end else begin
        m_en = 1'b0; m_reg = '0; m_data = '0; m_mc = 1'b0;
      end
      if (m_en) rf_model[m_reg] = m_data;
      if (mv && rdy_before) begin
        if (mc_todo[0].r != 0) mq.push_back(mc_todo[0]);
        mc_todo.delete(0);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, '0);
  endtask

  task automatic add_mc(input logic [AW-1:0] r, input logic [DW-1:0] d);
    wr_t w;
    w.r = r;
    w.d = d;
    mc_todo.push_back(w);
  endtask

  // Monitor: compares the DUT against the oldest prediction once per cycle
  exp_t mon_e;
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (expq.size() > 0) begin
        mon_e = expq.pop_front();
        chk("wr_en",      32'(wr_en),      32'(mon_e.en));
        chk("wr_reg",     32'(wr_reg),     32'(mon_e.r));
        chk("wr_data",    wr_data,         mon_e.d);
        chk("fifo_count", 32'(fifo_count), 32'(mon_e.cnt));
        chk("mc_ready",   32'(mc_ready),   32'(mon_e.rdy));
        chk("busy_mask",  busy_mask,       mon_e.busy);
        if (wr_en) rf_dut[wr_reg] = wr_data;
      end
    end
  end

  int txn;
  int guard;

  initial begin
    for (int i = 0; i < 32; i++) begin
      rf_model[i] = '0;
      rf_dut[i]   = '0;
    end
    rst = 1'b1;
    pipe_wr_en = 1'b0; pipe_wr_reg = '0; pipe_wr_data = '0;
    mc_valid = 1'b0; mc_wr_reg = '0; mc_wr_data = '0;
    @(posedge clk);
    #1;
    step(1'b1, 1'b0, '0, '0);
    step(1'b1, 1'b0, '0, '0);
    idle(2);

    // Pipeline write only
    step(1'b0, 1'b1, 5'd5, 32'hDEADBEEF);
    idle(2);

    // Single multi-cycle result with the pipeline idle
    add_mc(5'd7, 32'h12345678);
    idle(5);

    // Contention: pipeline busy every cycle while five multi-cycle results arrive
    for (int i = 1; i <= 5; i++) add_mc(AW'(i), 32'hA000_0000 + i);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, AW'(10 + i % 4), 32'hB000_0000 + i);
    idle(8);

    // x0 filtering on both sources
    add_mc(5'd0, 32'hFFFF_FFFF);
    step(1'b0, 1'b1, 5'd0, 32'hFFFF_FFFF);
    idle(3);

    // Reset with three entries queued
    for (int i = 1; i <= 3; i++) add_mc(AW'(i), 32'hC000_0000 + i);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, AW'(20 + i), 32'hD000_0000 + i);
    step(1'b1, 1'b0, '0, '0);
    idle(4);

    // Random mix; pipeline and multi-cycle destinations are disjoint so no WAW hazard arises
    txn = 0;
    guard = 0;
    while (txn < 1000 && guard < 5000) begin
      bit pe;
      logic [AW-1:0] pr;
      guard++;
      if (mc_todo.size() == 0 && $urandom_range(0, 9) < 7) begin
        add_mc(($urandom_range(0, 15) == 0) ? AW'(0) : AW'($urandom_range(1, 15)), $urandom);
        txn++;
      end
      pe = ($urandom_range(0, 1) == 1);
      pr = ($urandom_range(0, 15) == 0) ? AW'(0) : AW'($urandom_range(16, 31));
      if (pe) txn++;
      step(1'b0, pe, pr, $urandom);
    end

    // Drain everything outstanding, bounded
    guard = 0;
    while ((mc_todo.size() > 0 || mq.size() > 0) && guard < 64) begin
      idle(1);
      guard++;
    end
    checks++;
    if (mc_todo.size() > 0 || mq.size() > 0) begin
      failures++;
      $display("FAIL drain actual=%0d expected=0", mc_todo.size() + mq.size());
    end
    idle(3);
    @(negedge clk);
    @(negedge clk);

    checks++;
    if (expq.size() != 0) begin
      failures++;
      $display("FAIL expq_empty actual=%0d expected=0", expq.size());
    end
    for (int i = 0; i < 32; i++) chk("regfile", rf_dut[i], rf_model[i]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
